// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: opcodes, funct3 values, FSM states.
// Also holds the access-size decode used by the byte-serial sequencer.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  // Bytes moved per access; funct3 values beyond word size fall back to a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Formats the assembled load bytes into the register value (sign/zero extend).
// Purely combinational, no backpressure.
module mem_stage_load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_buf,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_result = i_buf;
    case (i_funct3)
      FUNCT3_LB:  o_result = {{(XLEN-8){i_buf[7]}}, i_buf[7:0]};
      FUNCT3_LH:  o_result = {{(XLEN-16){i_buf[15]}}, i_buf[15:0]};
      FUNCT3_LBU: o_result = {{(XLEN-8){1'b0}}, i_buf[7:0]};
      FUNCT3_LHU: o_result = {{(XLEN-16){1'b0}}, i_buf[15:0]};
      default:    o_result = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over a shared 8-bit RAM port, stalling the pipe while busy.
// Load n+2 / store n+1 cycles with continuous grant; waits on ram_grant, freezes on rdy_in low.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              hold_in,
  input  logic              forward,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   rd_val,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        ins_details,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_val,
  input  logic              ram_grant,
  input  logic [7:0]        ram_din,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              stall_req,
  output logic              output_forward,
  output logic [4:0]        output_rd_addr,
  output logic [XLEN-1:0]   output_rd_val
);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;
  logic [2:0]      r_idx;
  logic            r_pend;
  logic [XLEN-1:0] r_buf;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic [2:0]      w_nbytes;
  logic            w_last;
  logic            w_issue;
  logic [1:0]      w_cap_sel;
  logic [XLEN-1:0] w_ext;

  assign w_is_load  = (ins_type == OP_LOAD);
  assign w_is_store = (ins_type == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_nbytes   = access_bytes(ins_details);
  assign w_last     = (r_idx == (w_nbytes - 3'd1));
  assign w_issue    = (r_state == ST_ACCESS) && ram_grant && rdy_in;
  // The read byte returned now belongs to the byte issued one grant earlier.
  assign w_cap_sel  = r_idx[1:0] - 2'd1;

  mem_stage_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_buf    (r_buf),
    .i_funct3 (ins_details),
    .o_result (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_is_mem) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (ram_grant && w_last) w_state_nxt = w_is_load ? ST_WAIT : ST_DONE;
      ST_WAIT:   w_state_nxt = ST_DONE;
      ST_DONE:   if (!hold_in) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_pend  <= 1'b0;
      r_buf   <= ZeroWord[XLEN-1:0];
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_pend  <= w_issue && w_is_load;
      if (r_state == ST_IDLE) begin
        r_idx <= 3'd0;
        r_buf <= ZeroWord[XLEN-1:0];
      end else if (w_issue) begin
        r_idx <= r_idx + 3'd1;
      end
      if (r_pend) r_buf[{w_cap_sel, 3'b000} +: 8] <= ram_din;
    end
  end

  always_comb begin
    ram_req        = 1'b0;
    ram_wr         = 1'b0;
    ram_addr       = '0;
    ram_dout       = 8'h00;
    stall_req      = 1'b0;
    output_forward = forward;
    output_rd_addr = rd_addr;
    output_rd_val  = rd_val;
    if (rst_in) begin
      case (r_state)
        ST_IDLE:   stall_req = w_is_mem;
        ST_ACCESS: begin
          stall_req = 1'b1;
          ram_req   = 1'b1;
          ram_wr    = w_is_store;
          ram_addr  = mem_addr + ADDR_W'(r_idx);
          ram_dout  = mem_val[{r_idx[1:0], 3'b000} +: 8];
        end
        ST_WAIT:   stall_req = 1'b1;
        ST_DONE: begin
          if (w_is_load)       output_rd_val  = w_ext;
          else if (w_is_store) output_forward = 1'b0;
        end
        default: ;
      endcase
      if (stall_req) output_forward = 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the in-order RISC-V pipeline. Sits between the EX/MEM and MEM/WB pipeline registers.
- Consumes the EX/MEM register outputs and executes loads/stores byte-serially over the shared 8-bit RAM port. The RAM port is arbitrated against instruction fetch.
- Raises stall_req while an access is in flight.
- Presents writeback data, combinationally, to the MEM/WB register.

Parameters:
- ADDR_W, 32, address width (mem_addr, ram_addr)
- XLEN, 32, data width (rd_val, mem_val, output_rd_val)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state
- hold_in  in  1  MEM/WB held by stall controller
- forward  in  1  instruction writes rd
- rd_addr  in  5  destination register
- rd_val  in  32  ALU result
- ins_type  in  7  opcode
- ins_details  in  3  funct3
- mem_addr  in  32  effective address
- mem_val  in  32  store data
- ram_grant  in  1  arbiter grants ram_req this cycle
- ram_din  in  8  read byte; valid the cycle after a granted read
- ram_req  out  1  access request
- ram_wr  out  1  1=write, 0=read
- ram_addr  out  32  byte address
- ram_dout  out  8  write byte
- stall_req  out  1  to stall controller; holds IF..EX/MEM
- output_forward  out  1  to MEM/WB
- output_rd_addr  out  5  to MEM/WB
- output_rd_val  out  32  to MEM/WB

Behaviour:

Instruction classes:
- Load: ins_type=OP_LOAD (7'b0000011).
- Store: ins_type=OP_STORE (7'b0100011).
- Anything else is pass-through.

Access size n from funct3[1:0]:
- 00 → 1 byte
- 01 → 2 bytes
- 10/11 → 4 bytes

Addressing:
- Little-endian; byte i at mem_addr+i, 32-bit wrap.
- No alignment requirement.

FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Pass-through op: outputs = inputs, stall_req=0, ram_req=0.
  - Memory op: stall_req=1 → ACCESS, with i=0 and buffer cleared.
- ACCESS:
  - ram_req=1, ram_addr=mem_addr+i, ram_wr=is_store, ram_dout=mem_val[8i+7:8i].
  - On ram_grant: i++.
  - On the granted issue of the last byte: load → WAIT; store → DONE.
  - No grant: address and byte held, i unchanged.
- Read capture:
  - Every granted read raises pend for one cycle.
  - When pend=1, ram_din is written to buffer byte (i-1), regardless of the current grant.
- WAIT: captures the last byte → DONE. ram_req=0.
- DONE:
  - stall_req=0.
  - Load: output_rd_val = extended buffer. Store: output_forward=0.
  - → IDLE unless hold_in=1, in which case stay in DONE.
- stall_req = (IDLE & memory op) | ACCESS | WAIT.
- output_forward is forced to 0 whenever stall_req=1.

Load extension, funct3:
- 000 sign-extend bit 7
- 001 sign-extend bit 15
- 100/101 zero-extend
- others: full word

Store funct3 other than 000/001 is treated as SW. Loads to x0 still access RAM; forward is passed as given.

Latency with continuous grant, counting the detect cycle as 0:
- Load: n+2 cycles to DONE (LW: DONE at cycle 6).
- Store: n+1 cycles to DONE.

rdy_in=0:
- FSM, i, pend and buffer all frozen.
- ram_req stays asserted; the arbiter must not grant.

Reset:
- Forces IDLE, i=0, pend=0, buffer=0; ram_req/ram_wr/stall_req drop immediately.
- Bytes of a partial store already written stay written.
- After release, an op still presented restarts at byte 0.

Outputs during reset: ram_addr/ram_dout 0; output_* pass through the inputs.

Decomposition:
- Shared package/defines: OP_LOAD, OP_STORE, FUNCT3_* encodings, FSM state encoding, ZeroWord.
- One natural sub-module: load_extend. Combinational, buffer + funct3 → 32-bit result.

Test Plan:
1. Pass-through: ADDI opcode, rd=5, rd_val=0x1234, forward=1 → same-cycle outputs 1/5/0x1234; stall_req=0; ram_req never high.
2. LW at 0x100, RAM bytes 78 56 34 12, grant always → ram_addr 0x100..0x103 in cycles 1–4; stall_req low only in cycle 6; output_rd_val=0x12345678.
3. Extension: LB on 0x80 → 0xFFFFFF80; LBU → 0x00000080; LH with bytes 00 80 → 0xFFFF8000; LHU → 0x00008000.
4. SH at 0x200, mem_val=0xDEADBEEF → EF@0x200 then BE@0x201 with ram_wr=1; DONE at cycle 3; output_forward=0.
5. Grant withheld in cycles 2–4 of an LW → ram_addr stays 0x101; completion 3 cycles late with the correct value. Repeat with rdy_in=0 instead: the same freeze occurs. Also hold_in=1 keeps DONE and causes no re-access.
6. rst_in driven low after 2 bytes of an LW → ram_req and stall_req drop immediately; after release the op restarts at 0x100 and returns the correct result.
